// File: rtl/imem_dmem_arbiter_pkg.sv
// Shared types and constants for the IF/LS unified-memory arbiter.
package imem_dmem_arbiter_pkg;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_LS = 1'b1
   } owner_e;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } state_e;

   localparam int PKG_DATA_W = 32;
   localparam logic [PKG_DATA_W/8-1:0] BE_ALL = {PKG_DATA_W/8{1'b1}};

endpackage

// File: rtl/imem_dmem_arbiter_if.sv
// Core-side request/response and memory-side bus of the arbiter.
interface imem_dmem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   localparam int BE_W = DATA_W/8;

   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_gnt;
   logic              if_rvalid;
   logic [DATA_W-1:0] if_rdata;

   logic              ls_req;
   logic              ls_we;
   logic [BE_W-1:0]   ls_be;
   logic [ADDR_W-1:0] ls_addr;
   logic [DATA_W-1:0] ls_wdata;
   logic              ls_gnt;
   logic              ls_rvalid;
   logic [DATA_W-1:0] ls_rdata;

   logic              mem_req;
   logic              mem_we;
   logic [BE_W-1:0]   mem_be;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   logic              stall;

   modport slave (
      input  if_req, if_addr, ls_req, ls_we, ls_be, ls_addr, ls_wdata, mem_rdata,
      output if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
             mem_req, mem_we, mem_be, mem_addr, mem_wdata, stall
   );

   modport master (
      output if_req, if_addr, ls_req, ls_we, ls_be, ls_addr, ls_wdata, mem_rdata,
      input  if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
             mem_req, mem_we, mem_be, mem_addr, mem_wdata, stall
   );

endinterface

// File: rtl/imem_dmem_arbiter_starve_ctr.sv
// Saturating count of consecutive fetch denials; flags when IF must win.
module arb_starve_ctr #(
   parameter int STARVE_MAX = 3
) (
   input  logic clk,
   input  logic reset,
   input  logic if_req,
   input  logic if_gnt,
   output logic if_prio
);
   localparam int CW = $clog2(STARVE_MAX + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
      end else if (if_gnt) begin
         cnt <= '0;
      end else if (if_req && cnt != CNT_MAX) begin
         cnt <= cnt + CW'(1);
      end
   end

   assign if_prio = (cnt == CNT_MAX);

endmodule

// File: rtl/imem_dmem_arbiter.sv
// Single-port memory arbiter between instruction fetch and load/store,
// tracking the one outstanding read and stalling the core until it returns.
module imem_dmem_arbiter
   import imem_dmem_arbiter_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int MEM_LAT    = 1,
   parameter int STARVE_MAX = 3
) (
   input logic                   clk,
   input logic                   reset,
   imem_dmem_arbiter_if.slave    bus
);
   localparam int BE_W = DATA_W/8;
   localparam logic [BE_W-1:0] IF_BE    = {BE_W{1'b1}};
   localparam logic [1:0]      LAT_INIT = 2'(MEM_LAT - 1);

   typedef struct packed {
      logic              req;
      logic              we;
      logic [BE_W-1:0]   be;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } mreq_t;

   state_e     state;
   owner_e     owner;
   logic [1:0] lat_cnt;

   logic  can_issue, if_prio, if_win, ls_win, rd_grant, rd_done;
   mreq_t mreq;

   // Issue is allowed in the return cycle so a new access overlaps the rvalid.
   assign rd_done   = (state == WAIT) && (lat_cnt == 2'd0);
   assign can_issue = reset && ((state == IDLE) || rd_done);

   assign if_win   = can_issue & bus.if_req & (if_prio | ~bus.ls_req);
   assign ls_win   = can_issue & bus.ls_req & ~(if_prio & bus.if_req);
   assign rd_grant = if_win | (ls_win & ~bus.ls_we);

   arb_starve_ctr #(
      .STARVE_MAX (STARVE_MAX)
   ) u_starve (
      .clk     (clk),
      .reset   (reset),
      .if_req  (bus.if_req),
      .if_gnt  (if_win),
      .if_prio (if_prio)
   );

   always_comb begin
      mreq = '0;
      if (if_win) begin
         mreq.req  = 1'b1;
         mreq.be   = IF_BE;
         mreq.addr = bus.if_addr;
      end else if (ls_win) begin
         mreq.req   = 1'b1;
         mreq.we    = bus.ls_we;
         mreq.be    = bus.ls_be;
         mreq.addr  = bus.ls_addr;
         mreq.wdata = bus.ls_wdata;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         owner   <= OWN_IF;
         lat_cnt <= 2'd0;
      end else if (rd_grant) begin
         state   <= WAIT;
         owner   <= if_win ? OWN_IF : OWN_LS;
         lat_cnt <= LAT_INIT;
      end else if (state == WAIT) begin
         if (lat_cnt != 2'd0) lat_cnt <= lat_cnt - 2'd1;
         else                 state   <= IDLE;
      end
   end

   assign bus.if_gnt    = if_win;
   assign bus.ls_gnt    = ls_win;
   assign bus.if_rvalid = rd_done && (owner == OWN_IF);
   assign bus.ls_rvalid = rd_done && (owner == OWN_LS);
   assign bus.if_rdata  = bus.if_rvalid ? bus.mem_rdata : '0;
   assign bus.ls_rdata  = bus.ls_rvalid ? bus.mem_rdata : '0;

   assign bus.mem_req   = mreq.req;
   assign bus.mem_we    = mreq.we;
   assign bus.mem_be    = mreq.be;
   assign bus.mem_addr  = mreq.addr;
   assign bus.mem_wdata = mreq.wdata;

   assign bus.stall = (bus.if_req & ~if_win) | (bus.ls_req & ~ls_win) |
                      ((state == WAIT) && (lat_cnt != 2'd0));

endmodule
